// File: rtl/m_cache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package m_cache_pkg;

   localparam int DEF_WIDTH   = 32;
   localparam int DEF_ADDRESS = 10;
   localparam int DEF_LINES   = 16;

   typedef enum logic [1:0] {
      IDLE,
      LOOKUP,
      REQ,
      WAIT
   } state_t;

endpackage

// File: rtl/m_cache_if.sv
// Fetch-side and refill-side handshakes of m_cache; 'master' is the cache view, 'slave' the environment view.
interface m_cache_if
   import m_cache_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int ADDRESS = DEF_ADDRESS
);

   logic               m_read_i;
   logic [ADDRESS-1:0] m_addr_i;
   logic               m_mark_i;
   logic               m_rack_o;
   logic               m_ready_o;
   logic [WIDTH-1:0]   m_data_o;
   logic               m_mark_o;

   logic               s_read_o;
   logic [ADDRESS-1:0] s_addr_o;
   logic               s_rack_i;
   logic               s_ready_i;
   logic [WIDTH-1:0]   s_data_i;

   modport master (
      input  m_read_i, m_addr_i, m_mark_i, s_rack_i, s_ready_i, s_data_i,
      output m_rack_o, m_ready_o, m_data_o, m_mark_o, s_read_o, s_addr_o
   );

   modport slave (
      output m_read_i, m_addr_i, m_mark_i, s_rack_i, s_ready_i, s_data_i,
      input  m_rack_o, m_ready_o, m_data_o, m_mark_o, s_read_o, s_addr_o
   );

endinterface

// File: rtl/m_cache_ram.sv
// LINES x WIDTH data array: one synchronous read port, one write port, 1-cycle read latency.
module m_cache_ram #(
   parameter int WIDTH = 32,
   parameter int LINES = 16
) (
   input  logic                     clock_i,
   input  logic                     rd_en,
   input  logic [$clog2(LINES)-1:0] rd_addr,
   output logic [WIDTH-1:0]         rd_data,
   input  logic                     wr_en,
   input  logic [$clog2(LINES)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_data
);

   logic [WIDTH-1:0] mem [LINES];

   // No reset: contents survive reset by design.
   always_ff @(posedge clock_i) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
      if (rd_en)
         rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/m_cache.sv
// Direct-mapped one-word-per-line fetch cache: hit returns 1 cycle after rack, miss refills via slave port.
// Optional M_CACHE_INVALIDATE_EN adds invalidate_i to flush all valid bits; rack is withheld while a miss is outstanding.
module m_cache
   import m_cache_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int ADDRESS = DEF_ADDRESS,
   parameter int LINES   = DEF_LINES
) (
   input  logic clock_i,
   input  logic reset_i,
`ifdef M_CACHE_INVALIDATE_EN
   input  logic invalidate_i,
`endif
   m_cache_if.master bus
);

   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = ADDRESS - IDX_W;

   state_t             state_q, state_d;
   logic [ADDRESS-1:0] addr_q;
   logic               mark_q;
   logic               s_read_q;
   logic [LINES-1:0]   valid_q;
   logic [TAG_W-1:0]   tag_q [LINES];

   logic [IDX_W-1:0]   line;
   logic [TAG_W-1:0]   tag_in;
   logic               hit;
   logic               rack;
   logic               ready;
   logic               refill;
   logic               inv_all;
   logic [WIDTH-1:0]   ram_dat;
   logic [WIDTH-1:0]   ret_dat;

   assign line   = addr_q[IDX_W-1:0];
   assign tag_in = addr_q[ADDRESS-1:IDX_W];
   assign hit    = valid_q[line] && (tag_q[line] == tag_in);

`ifdef M_CACHE_INVALIDATE_EN
   assign inv_all = invalidate_i;
`else
   assign inv_all = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      rack    = 1'b0;
      ready   = 1'b0;
      refill  = 1'b0;
      ret_dat = ram_dat;
      case (state_q)
         IDLE: begin
            rack = bus.m_read_i;
            if (rack)
               state_d = LOOKUP;
         end
         LOOKUP: begin
            if (hit) begin
               ready   = 1'b1;
               rack    = bus.m_read_i;
               state_d = rack ? LOOKUP : IDLE;
            end else begin
               state_d = REQ;
            end
         end
         REQ: begin
            if (bus.s_rack_i)
               state_d = WAIT;
         end
         WAIT: begin
            if (bus.s_ready_i) begin
               ready   = 1'b1;
               refill  = 1'b1;
               ret_dat = bus.s_data_i;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // State is already IDLE under reset, but the handshakes must be quiet too.
      if (reset_i) begin
         rack   = 1'b0;
         ready  = 1'b0;
         refill = 1'b0;
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         mark_q   <= 1'b0;
         s_read_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         s_read_q <= (state_d == REQ);
         if (rack) begin
            addr_q <= bus.m_addr_i;
            mark_q <= bus.m_mark_i;
         end
      end
   end

   // A flush wins over a refill landing in the same cycle.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i)
         valid_q <= '0;
      else if (inv_all)
         valid_q <= '0;
      else if (refill)
         valid_q[line] <= 1'b1;
   end

   always_ff @(posedge clock_i) begin
      if (refill)
         tag_q[line] <= tag_in;
   end

   m_cache_ram #(
      .WIDTH (WIDTH),
      .LINES (LINES)
   ) u_ram (
      .clock_i (clock_i),
      .rd_en   (rack),
      .rd_addr (bus.m_addr_i[IDX_W-1:0]),
      .rd_data (ram_dat),
      .wr_en   (refill),
      .wr_addr (line),
      .wr_data (bus.s_data_i)
   );

   assign bus.m_rack_o  = rack;
   assign bus.m_ready_o = ready;
   assign bus.m_data_o  = ret_dat;
   assign bus.m_mark_o  = ready & mark_q;
   assign bus.s_read_o  = s_read_q;
   assign bus.s_addr_o  = addr_q;

endmodule

// File: tb/tb_m_cache.sv
// Directed bench for m_cache: slave memory model plus a scoreboard of expected returns, checked by assertions.
`timescale 1ns/100ps
module tb_m_cache;

   typedef struct packed {
      logic [31:0] d;
      logic        m;
   } exp_t;

   logic clock_i = 1'b0;
   logic reset_i = 1'b1;
`ifdef M_CACHE_INVALIDATE_EN
   logic invalidate_i = 1'b0;
`endif

   m_cache_if #(.WIDTH(32), .ADDRESS(10)) bus ();

   m_cache dut (
      .clock_i      (clock_i),
      .reset_i      (reset_i),
`ifdef M_CACHE_INVALIDATE_EN
      .invalidate_i (invalidate_i),
`endif
      .bus          (bus)
   );

   always #5 clock_i = ~clock_i;

   int vectors     = 0;
   int miscompares = 0;
   exp_t sb[$];

   int n_cyc    = 0;
   int rack_at  = -100;
   int ready_at = -100;
   int sread_at = -1;
   logic [9:0] saddr_at;
   logic rack_l, ready_l, sread_l;
   logic [9:0] saddr_l;

   function automatic logic [31:0] mem_word(input logic [9:0] a);
      return 32'hC0DE_0000 ^ {a, 6'h15, a, 6'h2A};
   endfunction

   // Slave: racks once s_read_o has been high rack_delay cycles, returns data the cycle after.
   int rack_delay = 0;
   int req_age    = 0;
   logic take, busy;
   logic [9:0] taddr;
   logic s_ready_drv = 1'b0;
   logic [31:0] s_data_drv = 32'h0;
   assign bus.s_rack_i  = bus.s_read_o && (req_age >= rack_delay);
   assign bus.s_ready_i = s_ready_drv;
   assign bus.s_data_i  = s_data_drv;

   always begin
      @(negedge clock_i);
      take  = bus.s_read_o && bus.s_rack_i;
      busy  = bus.s_read_o;
      taddr = bus.s_addr_o;
      @(posedge clock_i);
      #1;
      s_ready_drv = take;
      s_data_drv  = take ? mem_word(taddr) : 32'hDEAD_BEEF;
      req_age     = (busy && !take) ? req_age + 1 : 0;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   // One cycle: drive at +2, sample at +3, settle scoreboard.
   task automatic cyc(input logic rd, input logic [9:0] a, input logic mk);
      exp_t e;
      @(posedge clock_i);
      #2;
      bus.m_read_i = rd;
      bus.m_addr_i = a;
      bus.m_mark_i = mk;
      #1;
      n_cyc++;
      rack_l  = bus.m_rack_o;
      ready_l = bus.m_ready_o;
      sread_l = bus.s_read_o;
      saddr_l = bus.s_addr_o;
      if (sread_l && sread_at < 0) begin
         sread_at = n_cyc;
         saddr_at = saddr_l;
      end
      if (ready_l) begin
         ready_at = n_cyc;
         check("ready_has_request", sb.size() > 0, 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("m_data_o", bus.m_data_o, e.d);
            check("m_mark_o", bus.m_mark_o, e.m);
         end
      end
      if (rack_l) begin
         rack_at = n_cyc;
         sb.push_back('{d: mem_word(a), m: mk});
      end
   endtask

   task automatic fetch(input logic [9:0] a, input logic mk, input bit miss, input string tag);
      int got;
      int lat;
      sread_at = -1;
      cyc(1'b1, a, mk);
      check({tag, " rack"}, rack_l, 1);
      got = 0;
      for (int i = 0; i < 16 && got == 0; i++) begin
         cyc(1'b0, 10'h0, 1'b0);
         if (ready_l) got = 1;
      end
      lat = (got != 0) ? ready_at - rack_at : -1;
      check({tag, " latency"}, lat, miss ? 3 : 1);
      check({tag, " refill"}, sread_at >= 0, miss);
      if (miss) begin
         check({tag, " s_read timing"}, sread_at - rack_at, 2);
         check({tag, " s_addr_o"}, saddr_at, a);
      end
   endtask

   initial begin
      #100us;
      $display("FAIL timeout: simulation exceeded its time budget");
      $fatal(1, "timeout");
   end

   initial begin
      int got;
      bus.m_read_i = 1'b1;
      bus.m_addr_i = 10'h005;
      bus.m_mark_i = 1'b1;
      #3;
      check("reset m_rack_o",  bus.m_rack_o,  0);
      check("reset m_ready_o", bus.m_ready_o, 0);
      check("reset m_mark_o",  bus.m_mark_o,  0);
      check("reset s_read_o",  bus.s_read_o,  0);
      @(posedge clock_i);
      #2;
      reset_i      = 1'b0;
      bus.m_read_i = 1'b0;

      fetch(10'h005, 1'b0, 1'b1, "miss 0x005");
      fetch(10'h005, 1'b1, 1'b0, "hit 0x005");

      for (int a = 0; a < 4; a++)
         fetch(10'(a), 1'b0, 1'b1, "fill 0x00x");

      // Back-to-back hits stream one word per cycle.
      cyc(1'b1, 10'h000, 1'b0);
      check("b2b first rack", rack_l, 1);
      for (int i = 1; i < 4; i++) begin
         cyc(1'b1, 10'(i), i[0]);
         check("b2b ready", ready_l, 1);
         check("b2b rack", rack_l, 1);
      end
      cyc(1'b0, 10'h000, 1'b0);
      check("b2b last ready", ready_l, 1);
      cyc(1'b0, 10'h000, 1'b0);
      check("b2b no extra ready", ready_l, 0);

      fetch(10'h015, 1'b0, 1'b1, "alias 0x015");
      fetch(10'h005, 1'b1, 1'b1, "evicted 0x005");

      // Slow slave rack with a pending master request.
      rack_delay = 3;
      cyc(1'b1, 10'h007, 1'b0);
      check("slow rack accept", rack_l, 1);
      cyc(1'b1, 10'h009, 1'b1);
      check("slow lookup rack", rack_l, 0);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 10'h009, 1'b1);
         check("slow s_read_o", sread_l, 1);
         check("slow s_addr_o", saddr_l, 10'h007);
         check("slow m_rack_o", rack_l, 0);
      end
      cyc(1'b1, 10'h009, 1'b1);
      check("slow wait ready", ready_l, 1);
      check("slow wait rack", rack_l, 0);
      cyc(1'b1, 10'h009, 1'b1);
      check("slow next accept", rack_l, 1);
      rack_delay = 0;
      got = 0;
      for (int i = 0; i < 16 && got == 0; i++) begin
         cyc(1'b0, 10'h0, 1'b0);
         if (ready_l) got = 1;
      end
      check("slow 0x009 returned", got, 1);

      // Reset in WAIT: refill abandoned, late s_ready_i ignored.
      cyc(1'b1, 10'h015, 1'b0);
      cyc(1'b0, 10'h000, 1'b0);
      cyc(1'b0, 10'h000, 1'b0);
      check("pre-reset s_read_o", sread_l, 1);
      @(posedge clock_i);
      #2;
      reset_i      = 1'b1;
      bus.m_read_i = 1'b1;
      #1;
      check("wait-reset m_ready_o", bus.m_ready_o, 0);
      check("wait-reset m_rack_o",  bus.m_rack_o,  0);
      check("wait-reset m_mark_o",  bus.m_mark_o,  0);
      check("wait-reset s_read_o",  bus.s_read_o,  0);
      sb.delete();
      #0.5;
      reset_i      = 1'b0;
      bus.m_read_i = 1'b0;
      #0.5;
      check("late s_ready m_ready_o", bus.m_ready_o, 0);
      fetch(10'h005, 1'b0, 1'b1, "post-reset 0x005");
      fetch(10'h015, 1'b0, 1'b1, "aborted 0x015");

`ifdef M_CACHE_INVALIDATE_EN
      fetch(10'h015, 1'b1, 1'b0, "pre-flush 0x015");
      @(posedge clock_i);
      #2;
      invalidate_i = 1'b1;
      @(posedge clock_i);
      #2;
      invalidate_i = 1'b0;
      fetch(10'h015, 1'b1, 1'b1, "flushed 0x015");
`endif

      check("scoreboard drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/m_cache.md
M_CACHE -- requirements
Module: m_cache

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width.
REQ-002 SHALL have parameter ADDRESS, default 10, word-address width.
REQ-003 SHALL have parameter LINES, default 16 (power of 2), number of one-word direct-mapped lines; index = addr[log2(LINES)-1:0], tag = remaining upper bits.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clock_i in 1, the single rising-edge clock; reset_i in 1, asynchronous active-high reset.
REQ-005 Master-side ports SHALL be:
- m_read_i in 1: fetch request.
- m_addr_i in ADDRESS: fetch address.
- m_mark_i in 1: request tag.
- m_rack_o out 1: request accepted.
- m_ready_o out 1: data valid.
- m_data_o out WIDTH: fetched word.
- m_mark_o out 1: tag of the returned word.
REQ-006 Slave-side ports SHALL be:
- s_read_o out 1: refill request.
- s_addr_o out ADDRESS: refill address.
- s_rack_i in 1: refill request accepted.
- s_ready_i in 1: refill data valid.
- s_data_i in WIDTH: refill word.

Function
REQ-007 SHALL implement states IDLE, LOOKUP, REQ and WAIT.
REQ-008 m_rack_o SHALL equal m_read_i when in IDLE, or in LOOKUP on a hit; it SHALL be 0 otherwise. It is combinational. On acceptance, address and mark are registered and the state goes to LOOKUP.
REQ-009 The data array SHALL be read synchronously with m_addr_i in the acceptance cycle. Tags and valid bits SHALL be held in registers.
REQ-010 In LOOKUP, a hit SHALL be defined as valid[index] with stored tag == registered tag.
- On a hit: m_ready_o=1 in that same cycle (one cycle after rack), m_data_o = the array word, m_mark_o = the registered mark.
- Next state on a hit: LOOKUP if a new request is accepted, else IDLE.
- This gives one word per cycle on back-to-back hits.
REQ-011 In LOOKUP, a miss SHALL set m_ready_o=0 and move to REQ.
REQ-012 In REQ, s_read_o SHALL be 1 (registered) with s_addr_o = the registered address. Both SHALL be held until s_rack_i=1, then the state goes to WAIT.
REQ-013 In WAIT, on s_ready_i=1 the block SHALL:
- write s_data_i into the line, update its tag and set its valid bit;
- drive m_ready_o=1 with m_data_o = s_data_i (bypass) and m_mark_o = the registered mark;
- go to IDLE.
REQ-014 s_ready_i SHALL be ignored outside WAIT. s_read_o SHALL be 0 outside REQ.
REQ-015 With a slave that racks combinationally and returns data one cycle later, miss latency SHALL be 3 cycles from m_rack_o to m_ready_o.
REQ-016 m_data_o SHALL be don't-care when m_ready_o=0. m_ready_o SHALL never be 1 for two cycles per accepted request.
REQ-017 An address whose index aliases a valid line with a different tag SHALL miss and replace that line.

Reset
REQ-018 reset_i SHALL asynchronously clear all valid bits, enter IDLE, and force m_rack_o, m_ready_o, m_mark_o and s_read_o to 0.
REQ-019 Reset during REQ/WAIT SHALL abandon the refill with no line write; a late s_ready_i SHALL be ignored.
REQ-020 Data array contents SHALL be unaffected by reset.

Configuration
REQ-021 With M_CACHE_INVALIDATE_EN defined, the block SHALL add input invalidate_i (1 bit) that clears all valid bits at the next clock edge in any state. A refill completing in the same cycle SHALL still be returned to the master but its line SHALL be left invalid.
REQ-022 Without M_CACHE_INVALIDATE_EN, the port SHALL be absent and valid bits SHALL be cleared only by reset.

Structure
REQ-023 Package m_cache_pkg SHALL hold the state enum and the default WIDTH/ADDRESS/LINES constants.
REQ-024 The data array SHALL be sub-module m_cache_ram: synchronous, one read port and one write port, LINES x WIDTH.

Verification
REQ-025 Reset, then fetch 0x005: m_rack_o=1; s_read_o with s_addr_o=0x005 2 cycles later; m_ready_o=1 and m_data_o = memory[0x005] 3 cycles after rack.
REQ-026 Repeat fetch 0x005 with mark=1: m_ready_o=1 one cycle after rack, s_read_o stays 0, m_mark_o=1.
REQ-027 Fetch 0x000..0x003 back-to-back after they are cached: four consecutive m_ready_o=1 cycles with data in address order.
REQ-028 Fetch 0x015 after 0x005 (same index, LINES=16): miss, refill from 0x015; a following fetch of 0x005 misses again.
REQ-029 Delay s_rack_i by 3 cycles: s_read_o and s_addr_o held stable and m_rack_o=0 throughout.
REQ-030 Assert reset_i during WAIT: outputs 0 immediately; after release, fetch 0x005 misses.
